// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared RV32M divide opcodes, divider FSM states and special-case result helper.
package rv32m_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] ALUC_DIV  = 5'b10100;
  localparam logic [4:0] ALUC_DIVU = 5'b10101;
  localparam logic [4:0] ALUC_REM  = 5'b10110;
  localparam logic [4:0] ALUC_REMU = 5'b10111;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
  // Divide-by-zero or signed overflow result; dvd is the raw (unsigned-view) dividend.
  function automatic logic [XLEN-1:0] div_special(input logic is_rem, input logic [XLEN-1:0] dvd, input logic div0);
    return div0 ? (is_rem ? dvd : '1) : (is_rem ? '0 : dvd);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on unsigned magnitudes.
module div_step
  import rv32m_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_bit,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_q
);
  // One extra bit keeps the compare exact when the partial remainder has its MSB set.
  logic [XLEN:0] w_sh;
  assign w_sh  = {i_rem, i_bit};
  assign o_q   = w_sh >= {1'b0, i_divisor};
  assign o_rem = o_q ? w_sh[XLEN-1:0] - i_divisor : w_sh[XLEN-1:0];
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M div/divu/rem/remu sequencer with RISC-V special cases.
// Define DIV_FASTPATH_EN to retire divide-by-zero and signed overflow straight from IDLE.
module div_sequencer
  import rv32m_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      aluc,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            divReady,
  output logic            busy,
  output logic [XLEN-1:0] result
);
  div_state_t r_state, w_next;
  logic [5:0] r_cnt;
  logic r_is_rem, r_neg_q, r_neg_r, r_div0, r_ovf;
  logic [XLEN-1:0] r_raw, r_q, r_rem, r_dvs, r_result;
  logic w_acc, w_sgn, w_div0, w_ovf, w_fast, w_qbit, w_last, w_neg;
  logic [XLEN-1:0] w_dvd_mag, w_dvs_mag, w_rem, w_quo, w_mag, w_final;
  assign w_acc = r_state == IDLE && start && (aluc inside {ALUC_DIV, ALUC_DIVU, ALUC_REM, ALUC_REMU});
  assign w_sgn = ~aluc[0];
  assign w_div0 = divisor == '0;
  assign w_ovf = w_sgn && dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == '1;
`ifdef DIV_FASTPATH_EN
  assign w_fast = w_div0 | w_ovf;
`else
  assign w_fast = 1'b0;
`endif
  assign w_dvd_mag = (w_sgn && dividend[XLEN-1]) ? -dividend : dividend;
  assign w_dvs_mag = (w_sgn && divisor[XLEN-1]) ? -divisor : divisor;
  // r_q shifts dividend bits out at the top while quotient bits fill in at the bottom.
  div_step u_step (
    .i_rem(r_rem),
    .i_bit(r_q[XLEN-1]),
    .i_divisor(r_dvs),
    .o_rem(w_rem),
    .o_q(w_qbit)
  );
  assign w_quo = {r_q[XLEN-2:0], w_qbit};
  assign w_last = r_cnt == 6'(XLEN-1);
  assign w_mag = r_is_rem ? w_rem : w_quo;
  assign w_neg = r_is_rem ? r_neg_r : r_neg_q;
  assign w_final = (r_div0 | r_ovf) ? div_special(r_is_rem, r_raw, r_div0) : (w_neg ? -w_mag : w_mag);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = w_fast ? DONE : RUN;
    else if (r_state == RUN && w_last) w_next = DONE;
    else if (r_state == DONE) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_is_rem <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0 <= 1'b0;
      r_ovf <= 1'b0;
      r_raw <= '0;
      r_q <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_result <= '0;
    end else if (w_acc) begin
      r_cnt <= '0;
      r_is_rem <= aluc[1];
      r_neg_q <= w_sgn & (dividend[XLEN-1] ^ divisor[XLEN-1]);
      r_neg_r <= w_sgn & dividend[XLEN-1];
      r_div0 <= w_div0;
      r_ovf <= w_ovf;
      r_raw <= dividend;
      r_q <= w_dvd_mag;
      r_rem <= '0;
      r_dvs <= w_dvs_mag;
      if (w_fast) r_result <= div_special(aluc[1], dividend, w_div0);
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 6'd1;
      r_q <= w_quo;
      r_rem <= w_rem;
      if (w_last) r_result <= w_final;
    end
  end
  assign divReady = r_state == DONE;
  assign busy = r_state == RUN;
  assign result = r_result;
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the core's iterative integer divider, serving RV32M `div`, `divu`, `rem` and `remu`. It sits beside the ALU and owns the operand and result registers, the iteration counter and the RISC-V special-case rules. Its `divReady` output feeds the control unit, which holds PC (`PCHold=1`) while a divide-class `aluc` (20–23) is decoded and `divReady` is low.

## Interface
- `XLEN`, 32, operand/result width; the iteration count equals `XLEN`.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  divide-class instruction present; high while decoded `aluc` is in 20–23.
- `aluc`  in  5  operation select: `5'b10100` div, `5'b10101` divu, `5'b10110` rem, `5'b10111` remu.
- `dividend`  in  XLEN  rs1 value.
- `divisor`  in  XLEN  rs2 value.
- `divReady`  out  1  result valid this cycle; the core retires the instruction at the next edge.
- `busy`  out  1  high in RUN.
- `result`  out  XLEN  quotient or remainder; registered, holds until the next acceptance.

## Operation
- FSM with three states: IDLE, RUN, DONE. Reset puts it in IDLE with `divReady=0`, `busy=0`, `result=0`, counter=0 and all operand registers 0.
- **IDLE**
  - If `start=1`: capture `aluc`, the signedness and the operands, then go to RUN with the counter cleared.
  - If `start=0`: stay in IDLE.
- **Signed ops (div, rem)**
  - Operands are converted to magnitudes before iterating.
  - Quotient sign = sign(dividend) XOR sign(divisor).
  - Remainder sign = sign(dividend).
- **RUN**
  - Each cycle performs one restoring step: remainder = {remainder[XLEN-2:0], dividend MSB}; if remainder ≥ |divisor|, subtract and shift in quotient bit 1, else shift in 0.
  - Counter increments each step. After step XLEN-1, go to DONE with `result` loaded: quotient for div/divu, remainder for rem/remu, sign-corrected for signed ops.
  - `start` and all inputs are ignored during RUN.
- **Special cases** override `result` when it is loaded:
  - Divisor 0: div and divu give all-ones; rem and remu give the dividend.
  - Signed overflow (dividend = 0x80000000, divisor = −1): div gives 0x80000000; rem gives 0.
- **DONE**
  - `divReady=1` for exactly one cycle, then unconditionally go to IDLE.
  - A divide in the immediately following instruction is accepted in the next IDLE cycle, with no interference from the retired one.
- `rst` asserted during RUN or DONE aborts immediately: state returns to IDLE and outputs clear. No partial result is ever presented.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1 to XLEN: RUN, with `busy=1`.
- Cycle XLEN+1: DONE. For XLEN=32, `divReady` rises in cycle 33; the instruction occupies 34 cycles including retirement.
- `divReady` and `result` are driven from registers, with no combinational path from inputs.
- `result` is stable from the DONE cycle until the next acceptance edge.

## Configuration
- `DIV_FASTPATH_EN` defined: in IDLE, divisor-zero and signed-overflow cases skip RUN and go directly to DONE. `divReady` then rises in cycle 1.
- `DIV_FASTPATH_EN` undefined: every operation runs the full XLEN iterations; special cases are applied only at result load. Fixed latency of XLEN+1.
- Results are identical in both builds; only latency differs.

## Structure
- Shared package `rv32m_pkg` holds:
  - the `aluc` divide codes `ALUC_DIV`, `ALUC_DIVU`, `ALUC_REM`, `ALUC_REMU` (20–23), also used by the control unit;
  - the FSM state type {IDLE, RUN, DONE}.
- One sub-module, `div_step`: combinational, one restoring iteration. Inputs are partial remainder, next dividend bit and divisor; outputs are the new remainder and the quotient bit.

## Test plan
- divu 100 / 7 → `result`=14, `divReady` high only in cycle 33, `busy` high in cycles 1–32.
- rem −7 / 2 → 0xFFFFFFFF (−1); div −7 / 2 → 0xFFFFFFFD (−3), run back-to-back with a DONE→IDLE→accept gap of one cycle.
- div 5 / 0 → 0xFFFFFFFF; remu 5 / 0 → 5. With `DIV_FASTPATH_EN`, `divReady` in cycle 1; without it, in cycle 33.
- div 0x80000000 / 0xFFFFFFFF → 0x80000000; rem of the same operands → 0.
- Assert `rst` in cycle 10 of RUN → outputs 0 and state IDLE immediately. A new divu 9 / 3 started after reset completes with 3.
- Change `dividend`/`divisor` during RUN → `result` reflects only the operands captured at acceptance.
